clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_mon_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/clk_div_monitor.sv | 140 ++++++++++++++
 tb/tb_clk_div_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int DEF_EXP_PERIOD = 6;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_CNT_W      = 8;

  // True when period lies within exp_p +/- tol.
  function automatic logic in_range(input int period, input int exp_p, input int tol);
    return (period >= exp_p - tol) && (period <= exp_p + tol);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from first sampling edge to q.
// Backpressure: none; free-running.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of an asynchronous divided clock, flags out-of-range periods and reports lock.
// Latency: period_valid/err/locked update on the edge acting on a detected rise (3 clk after the input edge).
// Backpressure: none; status pulses are not held. Optional CLK_MON_TIMEOUT_EN adds a dead-clock timeout and stuck flag.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_divided,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  logic              div_sync;
  logic              div_prev;
  logic              rise;
  logic              capture;
  logic              period_ok;
  logic              timeout;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  mon_state_t        state;
  mon_state_t        state_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_divided),
    .q     (div_sync)
  );

  // Edge register: remembers the previous synchronised level for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_prev <= 1'b0;
    else        div_prev <= div_sync;
  end

  assign rise    = div_sync & ~div_prev;
  assign capture = rise && (state != IDLE);

  // cnt holds cycles since the last rise, so the period ending at this rise is cnt+1.
  assign period    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign period_ok = (period != CNT_MAX) && in_range(int'(period), EXP_PERIOD, TOL);

`ifdef CLK_MON_TIMEOUT_EN
  localparam int TIMEOUT_CNT = 2 * EXP_PERIOD;
  // Fires on the edge where cnt would reach TIMEOUT_CNT; a rise on that edge wins.
  assign timeout = (state != IDLE) && !rise && (int'(cnt) == TIMEOUT_CNT - 1);
`else
  assign timeout = 1'b0;
`endif

  // Period counter: held at 0 while idle, cleared on each rise, saturates otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (state == IDLE || rise)    cnt <= '0;
    else if (cnt != CNT_MAX)           cnt <= cnt + 1'b1;
  end

  // State and good-period run register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Next state: first rise only arms measurement; later rises grade the period.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      IDLE: begin
        if (rise) state_nxt = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        if (rise) begin
          if (period_ok) begin
            if (good_cnt != GOOD_MAX) good_nxt = good_cnt + 1'b1;
            if (good_nxt == GOOD_MAX) state_nxt = LOCKED;
          end else begin
            good_nxt  = '0;
            state_nxt = ACQUIRE;
          end
        end else if (timeout) begin
          good_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        good_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered measurement outputs; err covers both a bad period and a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out   <= '0;
      period_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      period_valid <= capture;
      err          <= (capture && !period_ok) || timeout;
      if (capture) period_out <= period;
    end
  end

`ifdef CLK_MON_TIMEOUT_EN
  // stuck is set by a timeout and held until the clock shows a rise again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stuck <= 1'b0;
    else if (rise)    stuck <= 1'b0;
    else if (timeout) stuck <= 1'b1;
  end
`else
  assign stuck = 1'b0;
`endif

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised bench for clk_div_monitor (CNT_W=8 and CNT_W=4 side by side) with a period-level reference model.
// Latency: model expects action 2 edges after the first edge sampling a new high level.
// Backpressure: n/a.
module tb_clk_div_monitor;

  localparam int EXP   = 6;
  localparam int TOL   = 0;
  localparam int LOCKN = 4;
  localparam int HMAX  = 32767;

  logic       clk;
  logic       rst_n;
  logic       clk_divided;
  logic [7:0] pout8;
  logic       pvld8, lock8, err8, stuck8;
  logic [3:0] pout4;
  logic       pvld4, lock4, err4, stuck4;

  int checks = 0;
  int errors = 0;

  clk_div_monitor u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_divided  (clk_divided),
    .period_out   (pout8),
    .period_valid (pvld8),
    .locked       (lock8),
    .err          (err8),
    .stuck        (stuck8)
  );

  clk_div_monitor #(.CNT_W(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_divided  (clk_divided),
    .period_out   (pout4),
    .period_valid (pvld4),
    .locked       (lock4),
    .err          (err4),
    .stuck        (stuck4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Rises are tracked as the edge index at which the monitor acts on them; a period is
  // the distance between two such edges, clipped to the counter maximum.
  bit samp [0:HMAX];
  int cyc        = 0;
  int first_live = 0;
  int m_max  [2] = '{255, 15};
  bit m_anch [2];
  int m_last [2];
  int m_run  [2];
  int m_pout [2];
  bit m_pvld [2];
  bit m_err  [2];
  bit m_stuck[2];

  function automatic bit vs(input int k);
    if (k < 0 || k < first_live || k > HMAX) return 1'b0;
    return samp[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_anch[i] = 0; m_last[i] = 0; m_run[i] = 0; m_pout[i] = 0;
      m_pvld[i] = 0; m_err[i] = 0; m_stuck[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int p, input bit det);
    int per;
    bit good;
    m_pvld[i] = 0;
    m_err[i]  = 0;
    if (det) begin
      if (!m_anch[i]) begin
        m_anch[i]  = 1;
        m_stuck[i] = 0;
      end else begin
        per  = p - m_last[i];
        if (per > m_max[i]) per = m_max[i];
        good = (per != m_max[i]) && (per >= EXP - TOL) && (per <= EXP + TOL);
        m_pout[i] = per;
        m_pvld[i] = 1;
        if (good) m_run[i] = (m_run[i] < LOCKN) ? m_run[i] + 1 : LOCKN;
        else begin
          m_run[i] = 0;
          m_err[i] = 1;
        end
      end
      m_last[i] = p;
    end
`ifdef CLK_MON_TIMEOUT_EN
    else if (m_anch[i] && (p - m_last[i] == 2 * EXP)) begin
      m_anch[i]  = 0;
      m_run[i]   = 0;
      m_err[i]   = 1;
      m_stuck[i] = 1;
    end
`endif
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    bit det;
    if (!rst_n) begin
      model_reset();
      first_live = cyc + 1;
    end else begin
      if (cyc <= HMAX) samp[cyc] = clk_divided;
      det = vs(cyc - 2) && !vs(cyc - 3);
      for (int i = 0; i < 2; i++) model_step(i, cyc, det);
    end
    cyc++;
  end

  // ---------------- per-cycle comparison ----------------
  int  err_cnt8 = 0;
  int  last_err_pout8 = -1;
  int  last_err_pout4 = -1;
  bit  stuck_seen8 = 0;
  bit  chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("w8_period_out", pout8, m_pout[0]);
      chk("w8_period_valid", pvld8, m_pvld[0]);
      chk("w8_locked", lock8, m_run[0] >= LOCKN);
      chk("w8_err", err8, m_err[0]);
      chk("w8_stuck", stuck8, m_stuck[0]);
      chk("w4_period_out", pout4, m_pout[1]);
      chk("w4_period_valid", pvld4, m_pvld[1]);
      chk("w4_locked", lock4, m_run[1] >= LOCKN);
      chk("w4_err", err4, m_err[1]);
      chk("w4_stuck", stuck4, m_stuck[1]);
      if (err8) err_cnt8++;
      if (err8 && pvld8) last_err_pout8 = pout8;
      if (err4 && pvld4) last_err_pout4 = pout4;
      if (stuck8) stuck_seen8 = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_period(input int hi, input int lo);
    for (int k = 0; k < hi; k++) begin @(negedge clk); clk_divided = 1'b1; end
    for (int k = 0; k < lo; k++) begin @(negedge clk); clk_divided = 1'b0; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int base;
    int hi, lo;
    rst_n       = 1'b1;
    clk_divided = 1'b0;
    #1 rst_n = 1'b0;
    chk_on = 1;

    // Reset held while the divided clock toggles: everything stays quiet.
    repeat (3) drive_period(1, 1);
    @(negedge clk) rst_n = 1'b1;

    // Nominal period 6: lock on the 5th rise, no errors.
    repeat (8) drive_period(3, 3);
    #2;
    chk("p6_locked", lock8, 1);
    chk("p6_no_err", err_cnt8, 0);

    // One long period of 9 while locked, then four good ones relock.
    base = err_cnt8;
    drive_period(4, 5);
    repeat (5) drive_period(3, 3);
    #2;
    chk("p9_err_once", err_cnt8 - base, 1);
    chk("p9_err_pout", last_err_pout8, 9);
    chk("p9_relocked", lock8, 1);

    // Randomised periods, biased toward nominal so lock is regularly reached and lost.
    repeat (80) begin
      if ($urandom_range(0, 3) != 0) begin hi = 3; lo = 3; end
      else begin hi = $urandom_range(1, 6); lo = $urandom_range(1, 6); end
      drive_period(hi, lo);
    end

    // 20-cycle gap after relocking.
    repeat (6) drive_period(3, 3);
    drive_period(3, 17);
    repeat (6) drive_period(3, 3);
    #2;
`ifndef CLK_MON_TIMEOUT_EN
    chk("gap20_w8_pout", last_err_pout8, 20);
    chk("gap20_w4_pout", last_err_pout4, 15);
`endif
    chk("gap20_relocked", lock8, 1);

    // Dead clock: long low stretch, then resume.
    stuck_seen8 = 0;
    drive_period(3, 300);
    repeat (7) drive_period(3, 3);
    #2;
`ifdef CLK_MON_TIMEOUT_EN
    chk("dead_stuck_seen", stuck_seen8, 1);
    chk("dead_stuck_clear", stuck8, 0);
`else
    chk("dead_w8_sat_pout", last_err_pout8, 255);
    chk("dead_w4_sat_pout", last_err_pout4, 15);
`endif
    chk("dead_relocked", lock8, 1);

    // Asynchronous reset between two rises while locked.
    repeat (2) begin @(negedge clk); clk_divided = 1'b1; end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_locked_w8", lock8, 0);
    chk("arst_locked_w4", lock4, 0);
    chk("arst_pvld_w8", pvld8, 0);
    repeat (3) begin @(negedge clk); clk_divided = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    repeat (8) drive_period(3, 3);
    #2;
    chk("arst_relocked", lock8, 1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
